w5300_bus_arbiter: RTL and testbench

Shares the single W5300 host bus between two requesters (m0: configuration/register path, m1: socket FIFO data path) and generates the chip-select/read/write strobe timing for each access. Sits between the W5300 driver's internal engines and the top-level W5300 pins (addr, data, cs_n, rd_n, wr_n) in the 100 MHz clock domain. Arbitration is round-robin; each access is a fixed-length SETUP/STROBE/HOLD cycle sized by parameters.

---
 rtl/w5300_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_w5300_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_bus_arbiter.sv
// w5300_bus_arbiter
//
// Shares the single W5300 host bus between two requesters and generates the
// chip-select and read/write strobe timing for each access. Requester m0 is
// the configuration/register path and m1 is the socket FIFO data path. When
// both are waiting, arbitration is round-robin. Each access is a fixed-length
// SETUP / STROBE / HOLD sequence, sized by parameters.
//
// Parameters
//   SETUP_CYCLES   cycles of cs_n low with addr/data valid before the strobe
//   STROBE_CYCLES  cycles rd_n/wr_n held low
//   HOLD_CYCLES    cycles of cs_n low with addr/data held after the strobe
//
// Ports
//   clk, rst                   100 MHz clock, synchronous active-high reset
//   m0_req/m1_req              access request, held until done
//   m0_we/m1_we                1 = write, 0 = read
//   m0_addr/m1_addr            W5300 register address
//   m0_wdata/m1_wdata          write data
//   m0_gnt/m1_gnt              owner of the bus, SETUP through HOLD
//   m0_done/m1_done            one-cycle completion pulse
//   rdata                      last read data (shared)
//   busy                       FSM not in IDLE
//   addr, data, cs_n, rd_n, wr_n   W5300 pins (data tri-stated unless writing)
//
// state  | meaning
// IDLE   | bus released, arbitrating between eligible requesters
// SETUP  | cs_n low, addr/data presented, strobes high
// STROBE | rd_n or wr_n low; read data captured on the final edge
// HOLD   | strobes high, cs_n/addr/data held; done pulses on exit

module w5300_bus_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 7,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [9:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [9:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [9:0]  addr,
  inout  wire  [15:0] data,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n
);

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("w5300_bus_arbiter: SETUP_CYCLES, STROBE_CYCLES and HOLD_CYCLES must all be >= 1");
  end

  localparam int MAX_SP = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_ALL = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int CW = $clog2(MAX_ALL + 1);

  // The counter is loaded with N-1 on state entry and the state exits when it
  // reads zero, so each state lasts exactly N cycles.
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           owner;     // 0 = m0, 1 = m1
  logic           last_gnt;  // 0 = m0, 1 = m1
  logic           we_q;
  logic [15:0]    wdata_q;
  logic           data_oe;

  logic elig0;
  logic elig1;
  logic pick1;

  // A requester whose done is pulsing this cycle is masked, so the other
  // side gets the done cycle and the same side waits at least one more cycle.
  assign elig0 = m0_req & ~m0_done;
  assign elig1 = m1_req & ~m1_done;
  // m1 wins when it is the only one eligible, or on a tie when m0 went last.
  assign pick1 = elig1 & (~elig0 | ~last_gnt);

  assign data = data_oe ? wdata_q : 16'hzzzz;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      data_oe  <= 1'b0;
      addr     <= '0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      rdata    <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            owner    <= pick1;
            last_gnt <= pick1;
            m0_gnt   <= ~pick1;
            m1_gnt   <= pick1;
            we_q     <= pick1 ? m1_we : m0_we;
            wdata_q  <= pick1 ? m1_wdata : m0_wdata;
            addr     <= pick1 ? m1_addr : m0_addr;
            data_oe  <= pick1 ? m1_we : m0_we;
            cs_n     <= 1'b0;
            cnt      <= SETUP_LOAD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            rd_n  <= we_q;
            wr_n  <= ~we_q;
            cnt   <= STROBE_LOAD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            if (!we_q) begin
              rdata <= data;
            end
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs_n    <= 1'b1;
            addr    <= '0;
            data_oe <= 1'b0;
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= ~owner;
            m1_done <= owner;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter. A W5300 read model drives the data
// pins while rd_n is low. Pull-ups make a released bus read as 16'hFFFF.
// Cycle k of an access is observed on the falling edge k half-periods after
// the rising edge that sampled the request (cycle 0).

module tb_w5300_bus_arbiter;

  logic clk;
  logic rst;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, busy;
  logic [15:0] rdata;
  logic [9:0]  addr;
  logic        cs_n, rd_n, wr_n;
  wire  [15:0] data;
  logic [15:0] model_rdata;

  logic        p_m0_req, p_m0_we, p_m1_req, p_m1_we;
  logic [9:0]  p_m0_addr, p_m1_addr;
  logic [15:0] p_m0_wdata, p_m1_wdata;
  logic        p_m0_gnt, p_m1_gnt, p_m0_done, p_m1_done, p_busy;
  logic [15:0] p_rdata;
  logic [9:0]  p_addr;
  logic        p_cs_n, p_rd_n, p_wr_n;
  wire  [15:0] p_data;
  logic [15:0] p_model_rdata;

  int checks;
  int errors;

  assign data   = (!rd_n)   ? model_rdata   : 16'hzzzz;
  assign p_data = (!p_rd_n) ? p_model_rdata : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup pu_a (data[i]);
    pullup pu_b (p_data[i]);
  end

  w5300_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .rdata(rdata), .busy(busy), .addr(addr), .data(data),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  w5300_bus_arbiter #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut_p (
    .clk(clk), .rst(rst),
    .m0_req(p_m0_req), .m0_we(p_m0_we), .m0_addr(p_m0_addr), .m0_wdata(p_m0_wdata),
    .m1_req(p_m1_req), .m1_we(p_m1_we), .m1_addr(p_m1_addr), .m1_wdata(p_m1_wdata),
    .m0_gnt(p_m0_gnt), .m1_gnt(p_m1_gnt), .m0_done(p_m0_done), .m1_done(p_m1_done),
    .rdata(p_rdata), .busy(p_busy), .addr(p_addr), .data(p_data),
    .cs_n(p_cs_n), .rd_n(p_rd_n), .wr_n(p_wr_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    checks++; if (rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b expected 1", rd_n); end
    checks++; if (wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b expected 1", wr_n); end
    checks++; if (addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", addr); end
    checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL reset_data_released: got %h expected FFFF", data); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_done, m1_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", {m0_done, m1_done}); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write;
    logic       ecs, ewr, edn, egn;
    logic [15:0] ed;
    logic [9:0]  ea;
    m0_we = 1'b1; m0_addr = 10'h008; m0_wdata = 16'h1234; m0_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ecs = !(k <= 9);
      ewr = !(k >= 2 && k <= 8);
      edn = (k == 10);
      egn = (k <= 9);
      ed  = (k <= 9) ? 16'h1234 : 16'hFFFF;
      ea  = (k <= 9) ? 10'h008 : 10'h000;
      checks++; if (cs_n !== ecs) begin errors++; $display("FAIL write_cs_n c%0d: got %b expected %b", k, cs_n, ecs); end
      checks++; if (wr_n !== ewr) begin errors++; $display("FAIL write_wr_n c%0d: got %b expected %b", k, wr_n, ewr); end
      checks++; if (rd_n !== 1'b1) begin errors++; $display("FAIL write_rd_n c%0d: got %b expected 1", k, rd_n); end
      checks++; if (data !== ed) begin errors++; $display("FAIL write_data c%0d: got %h expected %h", k, data, ed); end
      checks++; if (addr !== ea) begin errors++; $display("FAIL write_addr c%0d: got %h expected %h", k, addr, ea); end
      checks++; if (m0_gnt !== egn) begin errors++; $display("FAIL write_gnt c%0d: got %b expected %b", k, m0_gnt, egn); end
      checks++; if ({m0_done, m1_done} !== {edn, 1'b0}) begin errors++; $display("FAIL write_done c%0d: got %b expected %b", k, {m0_done, m1_done}, {edn, 1'b0}); end
      // Inputs changing mid-access must not leak onto the pins.
      if (k == 3) begin m0_wdata = 16'hFFFF; m0_addr = 10'h3FF; end
      if (k == 10) m0_req = 1'b0;
    end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL write_rdata_kept: got %h expected 0000", rdata); end
  endtask

  task automatic test_read;
    logic       ecs, erd, edn;
    logic [15:0] ed, er;
    model_rdata = 16'hA5C3;
    m1_we = 1'b0; m1_addr = 10'h02A; m1_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ecs = !(k <= 9);
      erd = !(k >= 2 && k <= 8);
      edn = (k == 10);
      ed  = (k >= 2 && k <= 8) ? 16'hA5C3 : 16'hFFFF;
      er  = (k >= 9) ? 16'hA5C3 : 16'h0000;
      checks++; if (cs_n !== ecs) begin errors++; $display("FAIL read_cs_n c%0d: got %b expected %b", k, cs_n, ecs); end
      checks++; if (rd_n !== erd) begin errors++; $display("FAIL read_rd_n c%0d: got %b expected %b", k, rd_n, erd); end
      checks++; if (wr_n !== 1'b1) begin errors++; $display("FAIL read_wr_n c%0d: got %b expected 1", k, wr_n); end
      checks++; if (data !== ed) begin errors++; $display("FAIL read_data_bus c%0d: got %h expected %h", k, data, ed); end
      checks++; if (rdata !== er) begin errors++; $display("FAIL read_rdata c%0d: got %h expected %h", k, rdata, er); end
      checks++; if (m1_gnt !== (k <= 9)) begin errors++; $display("FAIL read_gnt c%0d: got %b expected %b", k, m1_gnt, (k <= 9)); end
      checks++; if ({m0_done, m1_done} !== {1'b0, edn}) begin errors++; $display("FAIL read_done c%0d: got %b expected %b", k, {m0_done, m1_done}, {1'b0, edn}); end
      if (k == 10) m1_req = 1'b0;
    end
    m0_we = 1'b1; m0_addr = 10'h010; m0_wdata = 16'h5555; m0_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) begin
        checks++; if (m0_done !== 1'b1) begin errors++; $display("FAIL read_then_write_done: got %b expected 1", m0_done); end
        m0_req = 1'b0;
      end
    end
    checks++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL read_then_write_rdata: got %h expected A5C3", rdata); end
  endtask

  task automatic test_round_robin;
    int i, w;
    logic eg0, eg1, ed0, ed1, eb;
    logic [9:0] ea;
    do_reset();
    model_rdata = 16'h1111;
    m0_we = 1'b0; m0_addr = 10'h100;
    m1_we = 1'b1; m1_addr = 10'h200; m1_wdata = 16'h0F0F;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 81; c++) begin
      @(negedge clk);
      i = (c - 1) / 10;
      w = ((c - 1) % 10) + 1;
      if (c == 81) begin
        eg0 = 0; eg1 = 0; ed0 = 0; ed1 = 0; ea = 10'h000; eb = 0;
      end else begin
        eg0 = (w <= 9) && (i % 2 == 0);
        eg1 = (w <= 9) && (i % 2 == 1);
        ed0 = (w == 10) && (i % 2 == 0);
        ed1 = (w == 10) && (i % 2 == 1);
        ea  = (w <= 9) ? ((i % 2 == 0) ? 10'h100 : 10'h200) : 10'h000;
        eb  = (w <= 9);
      end
      checks++; if ({m0_gnt, m1_gnt} !== {eg0, eg1}) begin errors++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, {eg0, eg1}); end
      checks++; if ({m0_done, m1_done} !== {ed0, ed1}) begin errors++; $display("FAIL rr_done c%0d: got %b expected %b", c, {m0_done, m1_done}, {ed0, ed1}); end
      checks++; if (addr !== ea) begin errors++; $display("FAIL rr_addr c%0d: got %h expected %h", c, addr, ea); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL rr_busy c%0d: got %b expected %b", c, busy, eb); end
      if (c == 80) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
  endtask

  task automatic test_back_to_back;
    int j, w;
    logic erd;
    m0_we = 1'b0; m0_addr = 10'h020; model_rdata = 16'h0B00; m0_req = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      j = (c - 1) / 11;
      w = ((c - 1) % 11) + 1;
      erd = !(w >= 2 && w <= 8);
      checks++; if (m0_gnt !== (w <= 9)) begin errors++; $display("FAIL b2b_gnt c%0d: got %b expected %b", c, m0_gnt, (w <= 9)); end
      checks++; if (m0_done !== (w == 10)) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", c, m0_done, (w == 10)); end
      checks++; if (rd_n !== erd) begin errors++; $display("FAIL b2b_rd_n c%0d: got %b expected %b", c, rd_n, erd); end
      if (w == 9 || w == 10) begin
        checks++; if (rdata !== 16'h0B00 + 16'(j)) begin errors++; $display("FAIL b2b_rdata c%0d: got %h expected %h", c, rdata, 16'h0B00 + 16'(j)); end
      end
      if (w == 10) model_rdata = 16'h0B00 + 16'(j + 1);
      if (c == 32) m0_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    int done_at;
    m0_we = 1'b1; m0_addr = 10'h030; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wr_n !== 1'b0) begin errors++; $display("FAIL midrst_in_strobe: got wr_n %b expected 0", wr_n); end
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (wr_n !== 1'b1) begin errors++; $display("FAIL midrst_wr_n: got %b expected 1", wr_n); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n: got %b expected 1", cs_n); end
    checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL midrst_data_released: got %h expected FFFF", data); end
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got %b expected 0", m0_gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL midrst_rdata: got %h expected 0000", rdata); end
    seen = 0;
    for (int k = 7; k <= 20; k++) begin
      @(negedge clk);
      if (m0_done || m1_done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", seen); end
    m0_wdata = 16'hCAFE; m0_req = 1'b1;
    done_at = 0;
    for (int k = 1; k <= 20 && done_at == 0; k++) begin
      @(negedge clk);
      if (m0_done) done_at = k;
    end
    m0_req = 1'b0;
    checks++; if (done_at != 10) begin errors++; $display("FAIL midrst_reissue_done: got cycle %0d expected 10 (0 = timed out)", done_at); end
    @(negedge clk);
  endtask

  task automatic test_params;
    logic ecs, erd;
    logic [15:0] ed, er;
    p_model_rdata = 16'h3C5A;
    p_m0_we = 1'b0; p_m0_addr = 10'h055; p_m0_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ecs = !(k <= 7);
      erd = !(k >= 3 && k <= 5);
      ed  = (k >= 3 && k <= 5) ? 16'h3C5A : 16'hFFFF;
      er  = (k >= 6) ? 16'h3C5A : 16'h0000;
      checks++; if (p_cs_n !== ecs) begin errors++; $display("FAIL param_cs_n c%0d: got %b expected %b", k, p_cs_n, ecs); end
      checks++; if (p_rd_n !== erd) begin errors++; $display("FAIL param_rd_n c%0d: got %b expected %b", k, p_rd_n, erd); end
      checks++; if (p_wr_n !== 1'b1) begin errors++; $display("FAIL param_wr_n c%0d: got %b expected 1", k, p_wr_n); end
      checks++; if (p_data !== ed) begin errors++; $display("FAIL param_data c%0d: got %h expected %h", k, p_data, ed); end
      checks++; if (p_rdata !== er) begin errors++; $display("FAIL param_rdata c%0d: got %h expected %h", k, p_rdata, er); end
      checks++; if (p_m0_done !== (k == 8)) begin errors++; $display("FAIL param_done c%0d: got %b expected %b", k, p_m0_done, (k == 8)); end
      if (k == 8) p_m0_req = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    model_rdata = '0;
    p_m0_req = 0; p_m0_we = 0; p_m0_addr = '0; p_m0_wdata = '0;
    p_m1_req = 0; p_m1_we = 0; p_m1_addr = '0; p_m1_wdata = '0;
    p_model_rdata = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
